divu64_seq: RTL and testbench

DIVU64_SEQ -- requirements
Module: divu64_seq

---
 rtl/divu64_seq.sv | 120 ++++++++++++
 tb/tb_divu64_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/divu64_seq.sv
// 64-bit unsigned restoring divider, one quotient bit per cycle, MSB first.
// Latency: a start accepted at edge N pulses done in the cycle after edge N+64; a zero divisor pulses done after edge N.
// Backpressure: start is ignored while busy and is accepted only in IDLE or in the DONE cycle, which allows back-to-back operation.
module divu64_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [63:0] quotient,
    output logic [63:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic [6:0]  cnt;
    // quo_q starts out holding the dividend. Each RUN cycle shifts one dividend
    // bit out of its top and one quotient bit into its bottom.
    logic [63:0] quo_q;
    logic [63:0] rem_q;
    logic [63:0] dvs_q;
    logic        dbz_q;
    logic [64:0] shifted;
    logic [63:0] diff;
    logic        fits;

    // One restoring step: shift the partial remainder left, bring in the next
    // dividend bit, and test whether the divisor can be subtracted.
    always_comb begin
        shifted = {rem_q, quo_q[63]};
        fits    = (shifted >= {1'b0, dvs_q});
        // When fits is set the true difference is below the divisor, so it
        // needs only 64 bits and the wrapped subtraction is exact.
        diff    = shifted[63:0] - dvs_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, start acceptance and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (divisor == 64'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == 7'd63) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (divisor == 64'd0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture on acceptance, one division step per RUN cycle, and
    // results held unchanged otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 7'd0;
            quo_q <= 64'd0;
            rem_q <= 64'd0;
            dvs_q <= 64'd0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            cnt   <= 7'd0;
            dvs_q <= divisor;
            if (divisor == 64'd0) begin
                quo_q <= {64{1'b1}};
                rem_q <= dividend;
                dbz_q <= 1'b1;
            end else begin
                quo_q <= dividend;
                rem_q <= 64'd0;
                dbz_q <= 1'b0;
            end
        end else if (state == RUN) begin
            quo_q <= {quo_q[62:0], fits};
            rem_q <= fits ? diff : shifted[63:0];
            cnt   <= cnt + 7'd1;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu64_seq.sv
// Directed bench for divu64_seq: arithmetic reference model plus literal expectations.
// Drives inputs on the falling edge or 2 time units after the rising edge, and samples 2 time units after the rising edge.
// Every wait on done is bounded; an expired bound shows up as a latency miscompare.
module tb_divu64_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;

    int nvec  = 0;
    int nfail = 0;

    localparam logic [63:0] ONES = {64{1'b1}};

    divu64_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model.
    // busy_left counts the division cycles still to run. The published result
    // is what the outputs must show from the done pulse until the next accepted start.
    int          m_busy_left;
    logic        m_done;
    logic [63:0] pend_q, pend_r;
    logic [63:0] pub_q, pub_r;
    logic        pub_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy_left <= 0;
            m_done      <= 1'b0;
            pend_q      <= 64'd0;
            pend_r      <= 64'd0;
            pub_q       <= 64'd0;
            pub_r       <= 64'd0;
            pub_d       <= 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left <= m_busy_left - 1;
            m_done      <= (m_busy_left == 1);
            if (m_busy_left == 1) begin
                pub_q <= pend_q;
                pub_r <= pend_r;
                pub_d <= 1'b0;
            end
        end else if (start) begin
            if (divisor == 64'd0) begin
                m_done <= 1'b1;
                pub_q  <= ONES;
                pub_r  <= dividend;
                pub_d  <= 1'b1;
            end else begin
                m_done      <= 1'b0;
                m_busy_left <= 64;
                pend_q      <= dividend / divisor;
                pend_r      <= dividend % divisor;
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Compare the DUT against the model every cycle. The results are checked
    // whenever they are defined, which is at any time except during a division.
    always @(posedge clk) begin
        #2;
        chk("busy", {63'd0, busy}, {63'd0, (m_busy_left > 0)});
        chk("done", {63'd0, done}, {63'd0, m_done});
        if (m_busy_left == 0) begin
            chk("quotient", quotient, pub_q);
            chk("remainder", remainder, pub_r);
            chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, pub_d});
        end
    end

    // Count rising edges, including the accepting edge, until done is seen.
    task automatic wait_done(output int k);
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
            if (k == 1) start = 1'b0;
        end while (!done && k < 200);
    endtask

    task automatic run_div(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] eq, input logic [63:0] er,
                           input logic ed, input int elat);
        int k;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        wait_done(k);
        chk("latency", k, elat);
        chk("lit_quotient", quotient, eq);
        chk("lit_remainder", remainder, er);
        chk("lit_div_by_zero", {63'd0, div_by_zero}, {63'd0, ed});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 64'd0;
        divisor  = 64'd0;
        #3;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_quotient", quotient, 64'd0);
        chk("reset_remainder", remainder, 64'd0);
        chk("reset_dbz", {63'd0, div_by_zero}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start is accepted on the first edge after reset release.
        run_div(64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65);
        run_div(ONES, 64'd1, ONES, 64'd0, 1'b0, 65);
        run_div(ONES, ONES, 64'd1, 64'd0, 1'b0, 65);
        run_div(64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 65);
        run_div(64'd42, 64'd0, ONES, 64'd42, 1'b1, 1);
        run_div(64'd10, 64'd3, 64'd3, 64'd1, 1'b0, 65);
        run_div(64'h8000_0000_0000_0000, 64'd3, 64'h2AAA_AAAA_AAAA_AAAA, 64'd2, 1'b0, 65);

        // A start pulsed during RUN is ignored. A start issued in the DONE cycle
        // launches the next division with no gap.
        @(negedge clk);
        dividend = 64'd9;
        divisor  = 64'd4;
        start    = 1'b1;
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
            if (k == 1) start = 1'b0;
            if (k == 10) begin
                dividend = 64'd1000;
                divisor  = 64'd10;
                start    = 1'b1;
            end
            if (k == 11) start = 1'b0;
        end while (!done && k < 200);
        chk("ign_latency", k, 65);
        chk("ign_quotient", quotient, 64'd2);
        chk("ign_remainder", remainder, 64'd1);
        dividend = 64'd100;
        divisor  = 64'd10;
        start    = 1'b1;
        wait_done(k);
        chk("b2b_latency", k, 65);
        chk("b2b_quotient", quotient, 64'd10);
        chk("b2b_remainder", remainder, 64'd0);

        // Asserting reset mid-run aborts the division without a done pulse.
        @(negedge clk);
        dividend = 64'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #2;
            start = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_quotient", quotient, 64'd0);
        chk("abort_remainder", remainder, 64'd0);
        chk("abort_dbz", {63'd0, div_by_zero}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run_div(64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 65);

        repeat (3) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
